// File: rtl/burst_memory_pkg.sv
// Shared types and constants for burst_memory.
//   state_t   : controller states (IDLE, BURST_RD, BURST_WR)
//   DIR_READ  : burst_dir value selecting a read burst
//   DIR_WRITE : burst_dir value selecting a write burst
package burst_memory_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BURST_RD = 2'd1,
        BURST_WR = 2'd2
    } state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

endpackage : burst_memory_pkg

// File: rtl/burst_memory_sp_ram.sv
// Plain synchronous single-port RAM, no reset on the array or read register.
//   clk   : clock
//   en    : access enable
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, updated only on enabled reads
module sp_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // One access per cycle: either a write or a read, never both.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule : sp_ram

// File: rtl/burst_memory.sv
// Single-port RAM with single-cycle ren/wen access and a burst engine that
// streams consecutive words with address auto-increment and wrap-around.
//   clk, rst      : clock, synchronous active-high reset
//   ren, wen,addr : single read / write request (IDLE only), read has priority
//   din           : write data for single and burst writes
//   burst_start   : start a burst (IDLE only, beats ren/wen)
//   burst_dir     : 0 = read burst, 1 = write burst
//   burst_addr    : burst base address
//   burst_len     : burst length minus one
//   din_valid     : burst-write word present on din
//   din_ready     : high throughout a write burst
//   dout          : read data, zero whenever dout_valid is low
//   dout_valid    : dout carries read data this cycle
//   busy          : a burst is in progress
//   done          : one-cycle pulse when a burst completes
module burst_memory
    import burst_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ren,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  burst_start,
    input  logic                  burst_dir,
    input  logic [ADDR_WIDTH-1:0] burst_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  done
);

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   ptr, ptr_next;
    logic [LEN_WIDTH-1:0]    count, count_next;
    logic                    done_next;
    logic                    rd_issue;

    logic                    ram_en;
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State, pointer, count and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            din_ready  <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            count      <= count_next;
            dout_valid <= rd_issue;
            done       <= done_next;
            busy       <= (state_next != IDLE);
            din_ready  <= (state_next == BURST_WR);
        end
    end

    // Next-state, pointer/count update and RAM port steering.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        count_next = count;
        done_next  = 1'b0;
        rd_issue   = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = addr;
        ram_wdata  = din;

        case (state)
            IDLE: begin
                if (burst_start) begin
                    ptr_next   = burst_addr;
                    count_next = burst_len;
                    state_next = (burst_dir == DIR_WRITE) ? BURST_WR : BURST_RD;
                end else if (ren) begin
                    ram_en   = 1'b1;
                    rd_issue = 1'b1;
                end else if (wen) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                end
            end

            BURST_RD: begin
                ram_en   = 1'b1;
                ram_addr = ptr;
                rd_issue = 1'b1;
                ptr_next = ptr + ADDR_WIDTH'(1);
                if (count == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    count_next = count - LEN_WIDTH'(1);
                end
            end

            BURST_WR: begin
                if (din_valid) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = ptr;
                    ptr_next = ptr + ADDR_WIDTH'(1);
                    if (count == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        count_next = count - LEN_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A reset cycle must not disturb the array.
        if (rst) begin
            ram_en = 1'b0;
            ram_we = 1'b0;
        end
    end

    // Read data is exposed only in the cycle it is valid.
    assign dout = dout_valid ? ram_rdata : '0;

endmodule : burst_memory

// File: tb/tb_burst_memory.sv
// Scoreboard bench for burst_memory: stimulus pushes expected responses
// (with their due cycle) into a queue, a negedge monitor pops and compares.
module tb_burst_memory;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 7;
    localparam int unsigned LW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          ren, wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          burst_start, burst_dir;
    logic [AW-1:0] burst_addr;
    logic [LW-1:0] burst_len;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] dout;
    logic          dout_valid, busy, done;

    always #5 clk = ~clk;

    burst_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .ren(ren), .wen(wen), .addr(addr), .din(din),
        .burst_start(burst_start), .burst_dir(burst_dir), .burst_addr(burst_addr),
        .burst_len(burst_len), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
    );

    typedef struct {
        bit            rd;
        logic [DW-1:0] data;
        bit            dn;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] model [DEPTH];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    bit            mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Compare every presented output against the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_response: got nothing expected data %0h done %0d at cyc %0d",
                         q[0].data, q[0].dn, q[0].cyc);
                void'(q.pop_front());
            end
            if (dout_valid || done) begin
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output @cyc %0d: got valid %0d data %0h done %0d expected none",
                             cyc, dout_valid, dout, done);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("dout_valid", 32'(dout_valid), 32'(e.rd));
                    check("dout", 32'(dout), e.rd ? 32'(e.data) : 32'd0);
                    check("done", 32'(done), 32'(e.dn));
                end
            end else begin
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL late_response @cyc %0d: got no output expected data %0h done %0d",
                             cyc, q[0].data, q[0].dn);
                    void'(q.pop_front());
                end
                check("dout_idle_zero", 32'(dout), 32'd0);
            end
        end
    end

    task automatic idle_inputs();
        rst         = 1'b0;
        ren         = 1'b0;
        wen         = 1'b0;
        burst_start = 1'b0;
        din_valid   = 1'b0;
    endtask

    // Random requests that a busy block must ignore.
    task automatic noise();
        ren         = 1'($urandom_range(0, 1));
        wen         = 1'($urandom_range(0, 1));
        burst_start = 1'($urandom_range(0, 1));
        burst_dir   = 1'($urandom_range(0, 1));
        addr        = AW'($urandom);
        burst_addr  = AW'($urandom);
        burst_len   = LW'($urandom);
        din         = DW'($urandom);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle_inputs();
        wen  = 1'b1;
        addr = a;
        din  = d;
        model[a] = d;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        idle_inputs();
        ren  = 1'b1;
        addr = a;
        q.push_back('{1'b1, model[a], 1'b0, cyc + 1});
        @(negedge clk);
    endtask

    task automatic do_read_burst(input logic [AW-1:0] base, input int len, input bit with_ren);
        int c;
        idle_inputs();
        burst_start = 1'b1;
        burst_dir   = 1'b0;
        burst_addr  = base;
        burst_len   = LW'(len);
        ren         = with_ren;
        addr        = AW'($urandom);
        c = cyc;
        for (int k = 0; k <= len; k++) begin
            logic [AW-1:0] a;
            a = base + AW'(k);
            q.push_back('{1'b1, model[a], (k == len), c + 2 + k});
        end
        @(negedge clk);
        for (int i = 0; i <= len; i++) begin
            noise();
            check("busy_rd_burst", 32'(busy), 32'd1);
            @(negedge clk);
        end
        idle_inputs();
        check("busy_after_rd_burst", 32'(busy), 32'd0);
    endtask

    task automatic do_write_burst(input logic [AW-1:0] base, input int len,
                                  input logic [DW-1:0] data [16],
                                  input int stall_at, input int rst_at);
        idle_inputs();
        burst_start = 1'b1;
        burst_dir   = 1'b1;
        burst_addr  = base;
        burst_len   = LW'(len);
        @(negedge clk);
        for (int k = 0; k <= len; k++) begin
            int stalls;
            logic [AW-1:0] a;
            a = base + AW'(k);
            stalls = (k == stall_at) ? 2 : int'($urandom_range(0, 1));
            repeat (stalls) begin
                noise();
                din_valid = 1'b0;
                check("din_ready_stall", 32'(din_ready), 32'd1);
                check("busy_stall", 32'(busy), 32'd1);
                @(negedge clk);
            end
            noise();
            din_valid = 1'b1;
            din       = data[k];
            check("din_ready_accept", 32'(din_ready), 32'd1);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                idle_inputs();
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_din_ready", 32'(din_ready), 32'd0);
                check("rst_dout_valid", 32'(dout_valid), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_dout", 32'(dout), 32'd0);
                return;
            end
            model[a] = data[k];
            if (k == len) q.push_back('{1'b0, '0, 1'b1, cyc + 1});
            @(negedge clk);
        end
        idle_inputs();
        check("busy_after_wr_burst", 32'(busy), 32'd0);
        check("din_ready_after_wr_burst", 32'(din_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] wd [16];

        idle_inputs();
        burst_dir  = 1'b0;
        addr       = '0;
        din        = '0;
        burst_addr = '0;
        burst_len  = '0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_dout_valid", 32'(dout_valid), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_din_ready", 32'(din_ready), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Give every location a known value.
        for (int a = 0; a < int'(DEPTH); a++) do_write(AW'(a), DW'($urandom));

        // ren and wen together: read wins and nothing is written.
        do_write(AW'(5), 8'h3C);
        idle_inputs();
        ren  = 1'b1;
        wen  = 1'b1;
        addr = AW'(5);
        din  = 8'hC3;
        q.push_back('{1'b1, 8'h3C, 1'b0, cyc + 1});
        @(negedge clk);
        do_read(AW'(5));

        // Write immediately followed by a read of the same address.
        do_write(AW'(8'h10), 8'hA5);
        do_read(AW'(8'h10));

        // Wrapping write burst with a two-cycle stall before the third word.
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
        do_write_burst(AW'(8'h7E), 3, wd, 2, -1);

        // Wrapping read burst back over the same words, ren noise inside.
        do_read_burst(AW'(8'h7E), 3, 1'b0);
        do_read(AW'(8'h7F));
        do_read(AW'(8'h00));

        // burst_start beats ren in the same IDLE cycle.
        do_read_burst(AW'(8'h20), 2, 1'b1);

        // Reset on the second word of a len-7 write burst.
        for (int k = 0; k < 16; k++) wd[k] = DW'($urandom);
        do_write_burst(AW'(8'h40), 7, wd, -1, 1);
        for (int k = 0; k < 8; k++) do_read(AW'(8'h40 + k));

        // Randomized mix of single and burst accesses.
        for (int it = 0; it < 40; it++) begin
            int op;
            op = int'($urandom_range(0, 3));
            case (op)
                0: do_write(AW'($urandom), DW'($urandom));
                1: do_read(AW'($urandom));
                2: do_read_burst(AW'($urandom), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                default: begin
                    for (int k = 0; k < 16; k++) wd[k] = DW'($urandom);
                    do_write_burst(AW'($urandom), int'($urandom_range(0, 15)), wd, -1, -1);
                end
            endcase
        end

        // Sweep-read everything to expose stray writes.
        for (int a = 0; a < int'(DEPTH); a++) do_read(AW'(a));

        idle_inputs();
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_burst_memory
